iface_array_reader: RTL
=======================

// Module: iface_array_reader
//
// PURPOSE
//   Reader side of a [ROWS][COLS] instance array whose members each drive one
//   identification word. On start it snapshots the packed array and walks it row-major:
//   [0][0], [0][1], ..., [ROWS-1][COLS-1].
//   Each element is streamed out over a valid/ready port and checked against its
//   expected ID, {row, col}.
//   Used by self-checking benches in place of manual $display dumps of array members.
//
// PARAMETERS
//   ROWS  3   outer array dimension (1..255)
//   COLS  2   inner array dimension (1..255)
//   W     16  element width in bits (>= 16)
//
// PORTS
//   clk             in   1            clock, rising edge
//   rst_n           in   1            asynchronous active-low reset
//   start_i         in   1            begin scan; sampled only in IDLE
//   arr_i           in   ROWS*COLS*W  packed array; element [r][c] = arr_i[(r*COLS+c)*W +: W]
//   busy_o          out  1            high in SEND and DONE
//   out_valid_o     out  1            element available on out_*
//   out_ready_i     in   1            consumer accepts element
//   out_data_o      out  W            element value
//   out_row_o       out  8            row index of element
//   out_col_o       out  8            column index of element
//   out_last_o      out  1            element is [ROWS-1][COLS-1]
//   done_o          out  1            one-cycle pulse after last element is accepted
//   pass_o          out  1            last completed scan had zero mismatches
//   mismatch_cnt_o  out  8            mismatches in current/last scan, saturates at 255
//
// BEHAVIOUR
//   Reset: all outputs are 0, state is IDLE, snapshot is 0, row/col are 0.
//   Reset mid-scan aborts the scan and applies the same values.
//   States: IDLE -> SEND -> DONE -> IDLE.
//   - IDLE: when start_i=1, snapshot arr_i, clear row/col and mismatch_cnt_o, clear pass_o,
//     then go to SEND. out_valid_o rises on the next cycle (latency 1).
//   - SEND: out_valid_o=1. out_data_o = snap[row][col].
//     out_last_o = (row==ROWS-1 && col==COLS-1).
//   - Handshake: an element transfers when out_valid_o && out_ready_i at a clock edge.
//     While valid && !ready, every out_* signal holds stable.
//     There is no combinational path from ready to valid.
//   - On transfer: compare against expected {W-16 zeros, row[7:0], col[7:0]}.
//     If unequal, mismatch_cnt_o increments, holding at 255.
//     Then, if col==COLS-1: col=0, row++; otherwise col++.
//     On transfer of the last element: go to DONE, and out_valid_o is 0 the next cycle.
//   - DONE: exactly 1 cycle. done_o=1. pass_o is set to (final mismatch count == 0),
//     counting the last element. Then go to IDLE.
//   - pass_o and mismatch_cnt_o hold in IDLE until the next start.
//   - start_i while busy_o=1 is ignored.
//     start_i in the DONE cycle is ignored; the next start is accepted the cycle after.
//   - arr_i changes after the snapshot do not affect the scan in progress.
//   - With ready held high, one scan takes ROWS*COLS+2 cycles from start to the
//     return to IDLE. ROWS=COLS=1 gives a single element with out_last_o=1.
//
// TESTING
//   1. Reset, arr_i = correct IDs (0x0000,0x0001,0x0100,0x0101,0x0200,0x0201),
//      ready=1, start pulse -> 6 transfers in that order; last has out_last_o=1;
//      done_o 1 cycle later; pass_o=1, mismatch_cnt_o=0.
//   2. As 1, but element [1][0]=0xBEEF -> that element is streamed unchanged;
//      done_o; pass_o=0, mismatch_cnt_o=1.
//   3. ready toggled 1,0,0,1,... -> data/row/col hold through stalls; order and count
//      are unchanged; valid never drops before the last transfer.
//   4. arr_i changed and start re-pulsed during the scan -> streamed values match the
//      snapshot; the second start is ignored; exactly one done_o.
//   5. rst_n asserted after 3 transfers -> outputs go to 0 immediately; a new start then
//      scans from [0][0] with a fresh count.
//   6. ROWS=1, COLS=1, arr_i=0x0000 -> one transfer with out_last_o=1; done_o;
//      pass_o=1; total 3 cycles start-to-IDLE.

Source files
------------

// File: rtl/iface_array_reader.sv
// iface_array_reader: snapshots a packed [ROWS][COLS] array of ID words and
// streams it row-major over a valid/ready port. Each element is checked
// against its expected ID {row, col}, and the mismatches are counted.
module iface_array_reader #(
    parameter int ROWS = 3,
    parameter int COLS = 2,
    parameter int W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [ROWS*COLS*W-1:0] arr_i,
    output logic                   busy_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [W-1:0]           out_data_o,
    output logic [7:0]             out_row_o,
    output logic [7:0]             out_col_o,
    output logic                   out_last_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [7:0]             mismatch_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ROWS*COLS*W-1:0] r_snap;
    logic [7:0]             r_row;
    logic [7:0]             r_col;
    logic [7:0]             r_cnt;
    logic                   r_pass;

    logic [31:0]            w_idx;
    logic [W-1:0]           w_elem;
    logic [W-1:0]           w_exp;
    logic                   w_last;
    logic                   w_xfer;
    logic                   w_mis;
    logic [7:0]             w_cnt_nxt;

    // Row/col never leave the array range: they wrap to [0][0] on the last
    // transfer, so the element mux index is always in bounds.
    assign w_idx     = 32'(r_row) * 32'(COLS) + 32'(r_col);
    assign w_elem    = r_snap[w_idx*W +: W];
    assign w_exp     = W'({r_row, r_col});
    assign w_last    = (r_row == 8'(ROWS-1)) && (r_col == 8'(COLS-1));
    assign w_xfer    = (r_state == S_SEND) && out_ready_i;
    assign w_mis     = (w_elem != w_exp);
    assign w_cnt_nxt = (w_mis && (r_cnt != 8'hFF)) ? r_cnt + 8'd1 : r_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: IDLE -> SEND -> DONE (one cycle) -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_SEND;
            S_SEND:  if (out_ready_i && w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: snapshot on start, advance the index and count mismatches on
    // each transfer. The pass flag is latched with the last transfer, so it is
    // already valid in the DONE cycle alongside done_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_cnt  <= '0;
            r_pass <= 1'b0;
        end else if (r_state == S_IDLE && start_i) begin
            r_snap <= arr_i;
            r_row  <= '0;
            r_col  <= '0;
            r_cnt  <= '0;
            r_pass <= 1'b0;
        end else if (w_xfer) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
                r_row  <= '0;
                r_col  <= '0;
                r_pass <= (w_cnt_nxt == 8'd0);
            end else if (r_col == 8'(COLS-1)) begin
                r_col <= '0;
                r_row <= r_row + 8'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    // Outputs are purely registered state, so there is no path from ready
    // to valid. The payload is zeroed whenever valid is low.
    assign out_valid_o    = (r_state == S_SEND);
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = (r_state == S_DONE);
    assign out_data_o     = out_valid_o ? w_elem : '0;
    assign out_row_o      = out_valid_o ? r_row  : '0;
    assign out_col_o      = out_valid_o ? r_col  : '0;
    assign out_last_o     = out_valid_o && w_last;
    assign pass_o         = r_pass;
    assign mismatch_cnt_o = r_cnt;

endmodule
